// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Bit-counter width for a WIDTH-bit operand; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_add_cell.sv
// Combinational full-add cell built from two half adders.
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0, c0, c1;

    half_adder u_ha0 (.x(a),  .y(b),   .s(s0), .c(c0));
    half_adder u_ha1 (.x(s0), .y(cin), .s(s),  .c(c1));

    // The two half-adder carries can never both be set, so OR is exact.
    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder: the existing datapath primitive.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one bit per clock through a single full-add cell.
module serial_add_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sh, b_sh, acc;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               cell_s, cell_c;
    logic               last_bit;

    full_add_cell u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .s   (cell_s),
        .cout(cell_c)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)    state_nxt = ST_RUN;
            ST_RUN:  if (last_bit) state_nxt = ST_DONE;
            ST_DONE:               state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, serial shifting and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        acc   <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    acc   <= {cell_s, acc[WIDTH-1:1]};
                    carry <= cell_c;
                    // Wrap on the final bit is harmless: the FSM leaves RUN.
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        sum  <= {cell_s, acc[WIDTH-1:1]};
                        cout <= cell_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule
